// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and
// the bit-period helper used by both directions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read; a full FIFO drops pushes
// even when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int fifo_bit_len = 8,
    parameter int fifo_size    = 4
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [fifo_bit_len-1:0] data_in,
    output logic [fifo_bit_len-1:0] data_out,
    output logic [fifo_size:0]      count,
    output logic                    empty,
    output logic                    full
);
    localparam int DEPTH = 2 ** fifo_size;
    localparam logic [fifo_size:0] COUNT_MAX = {1'b1, {fifo_size{1'b0}}};

    logic [fifo_bit_len-1:0] mem [DEPTH];
    logic [fifo_size-1:0]    wr_ptr;
    logic [fifo_size-1:0]    rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full     = (count == COUNT_MAX);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (nreset && do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: FIFO-fed 8N1-style serialiser with back-to-back
// frames and a registered, glitch-free line output.
//
//  state | meaning
//  IDLE  | line high, waiting for a queued word
//  START | line low for one bit period
//  DATA  | shifting data bits out LSB first
//  STOP  | line high for one bit period, then next word or IDLE
module uart_buffered_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int Word_Len  = 8,
    parameter int fifo_size = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [Word_Len-1:0] tx_data_in,
    input  logic                tx_data_valid,
    output logic                tx_data_ready,
    output logic                tx_o,
    output logic                tx_busy,
    output logic [fifo_size:0]  fifo_count,
    output logic                fifo_empty,
    output logic                fifo_full
);
    localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W  = $clog2(Word_Len + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(Word_Len - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_buffered_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    tx_state_t           state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [Word_Len-1:0] shift;
    logic [Word_Len-1:0] fifo_head;
    logic                baud_tc;
    logic                pop;

    assign baud_tc       = (baud_cnt == BAUD_LAST);
    assign pop           = !fifo_empty && ((state == IDLE) || (state == STOP && baud_tc));
    assign tx_busy       = (state != IDLE);
    assign tx_data_ready = ~fifo_full;

    uart_sync_fifo #(
        .fifo_bit_len(Word_Len),
        .fifo_size   (fifo_size)
    ) u_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push    (tx_data_valid && tx_data_ready),
        .pop     (pop),
        .data_in (tx_data_in),
        .data_out(fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // tx_o is loaded with the level of the bit that starts at this edge.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= IDLE;
            tx_o     <= STOP_LEVEL;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (pop) begin
            shift    <= fifo_head;
            bit_idx  <= '0;
            baud_cnt <= '0;
            state    <= START;
            tx_o     <= START_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx_o     <= STOP_LEVEL;
                end
                START: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx_o     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                            tx_o  <= STOP_LEVEL;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx_o     <= STOP_LEVEL;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= STOP_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Bench for uart_buffered_tx: vector table, directed corner sequences and
// randomized traffic checked every cycle against a frame-level line model.
module tb_uart_buffered_tx;
    localparam int CPB   = 10;
    localparam int WL    = 8;
    localparam int FRAME = (WL + 2) * CPB;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] tx_data_in;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_o;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;

    always #5 clk = ~clk;

    uart_buffered_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000),
        .Word_Len (WL),
        .fifo_size(4)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .tx_data_in   (tx_data_in),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .tx_o         (tx_o),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: queue of waiting words, cycles left in the frame on the line, and that frame's word.
    logic [7:0] mq[$];
    int         rem = 0;
    logic [7:0] cur = 8'h00;

    function automatic logic exp_tx();
        int p;
        if (rem == 0) return 1'b1;
        p = (FRAME - rem) / CPB;
        if (p == 0) return 1'b0;
        if (p == WL + 1) return 1'b1;
        return cur[p-1];
    endfunction

    task automatic model_edge(input logic rst_n, input logic v, input logic [7:0] d);
        bit can_push;
        if (!rst_n) begin
            mq.delete();
            rem = 0;
        end else begin
            can_push = v && (mq.size() < DEPTH);
            if (mq.size() > 0 && rem <= 1) begin
                cur = mq.pop_front();
                rem = FRAME;
            end else if (rem > 0) begin
                rem--;
            end
            if (can_push) mq.push_back(d);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic rst_n, input logic v, input logic [7:0] d);
        @(negedge clk);
        nreset        = rst_n;
        tx_data_valid = v;
        tx_data_in    = d;
        @(posedge clk);
        model_edge(rst_n, v, d);
        #1;
        cyc++;
        check("tx_o", int'(tx_o), int'(exp_tx()));
        check("tx_busy", int'(tx_busy), (rem > 0) ? 1 : 0);
        check("fifo_count", int'(fifo_count), mq.size());
        check("fifo_empty", int'(fifo_empty), (mq.size() == 0) ? 1 : 0);
        check("fifo_full", int'(fifo_full), (mq.size() == DEPTH) ? 1 : 0);
        check("tx_data_ready", int'(tx_data_ready), (mq.size() < DEPTH) ? 1 : 0);
    endtask

    task automatic wait_idle(input int max_cyc, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < max_cyc && tx_busy; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (tx_busy) nbusy++;
        end
        check("wait_idle_done", int'(tx_busy), 0);
    endtask

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [7:0] d;
        logic       e_tx;
        logic       e_busy;
        int         e_count;
        logic       e_ready;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   nb;
        int   busy_seen;
        int   pct;
        int   phase_pct[8] = '{2, 20, 80, 5, 50, 1, 95, 10};

        nreset        = 1'b0;
        tx_data_valid = 1'b0;
        tx_data_in    = 8'h00;

        // Reset held with valid high, first push after release, then start bit and first data bit of 0xA5.
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1, 1'b1});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1});

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].v, vecs[i].d);
            check("vec_tx_o", int'(tx_o), int'(vecs[i].e_tx));
            check("vec_tx_busy", int'(tx_busy), int'(vecs[i].e_busy));
            check("vec_fifo_count", int'(fifo_count), vecs[i].e_count);
            check("vec_ready", int'(tx_data_ready), int'(vecs[i].e_ready));
        end
        wait_idle(200, nb);
        check("frame_a5_busy_cycles", nb + 11, FRAME);

        // Two words on consecutive cycles: one contiguous 200-cycle busy run.
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        wait_idle(400, nb);
        check("b2b_busy_cycles", nb + 1, 2 * FRAME);

        // Hold valid with 18 distinct words: 16 stored, the 18th refused.
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b1, 8'(8'h40 + i));
            if (i == 16) begin
                check("fill_full", int'(fifo_full), 1);
                check("fill_ready", int'(tx_data_ready), 0);
                check("fill_count", int'(fifo_count), 16);
            end
            if (i == 17) check("fill_reject_count", int'(fifo_count), 16);
        end
        // Keep pushing through the STOP->START pop: push refused, count drops to 15.
        for (int i = 0; i < 150 && fifo_count == 5'd16; i++) step(1'b1, 1'b1, 8'hEE);
        check("full_pop_count", int'(fifo_count), 15);
        check("full_pop_start_bit", int'(tx_o), 0);
        wait_idle(2000, nb);

        // Reset mid-frame with three words queued.
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        step(1'b1, 1'b1, 8'h44);
        check("abort_queued", int'(fifo_count), 3);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("abort_tx_o", int'(tx_o), 1);
        check("abort_busy", int'(tx_busy), 0);
        check("abort_count", int'(fifo_count), 0);
        check("abort_ready", int'(tx_data_ready), 1);
        busy_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (tx_busy || !tx_o) busy_seen++;
        end
        check("abort_no_frames", busy_seen, 0);

        // Randomized traffic with varying load and rare resets.
        for (int i = 0; i < 4000; i++) begin
            pct = phase_pct[(i / 500) % 8];
            step(($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0,
                 8'($urandom));
        end
        wait_idle(2500, nb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
